// File: rtl/shift_sequencer_pkg.sv
// Shared types for the multi-cycle shift sequencer.
// Mode and state encodings plus counter sizing.
package shift_sequencer_pkg;

   localparam int SEQ_WIDTH = 8;
   localparam int SEQ_CNT_W = $clog2(SEQ_WIDTH) + 1;

   typedef enum logic [1:0] {
      SHIFT_ROR = 2'b00,
      SHIFT_SLL = 2'b01,
      SHIFT_SRL = 2'b10,
      SHIFT_SRA = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SHIFT  = 2'b01,
      FINISH = 2'b10
   } state_e;

   // Count must hold WIDTH itself, not just WIDTH-1.
   function automatic int cnt_width(int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Start/done request bundle between control unit and sequencer.
// master drives the request, slave returns status and result.
interface shift_sequencer_if
   import shift_sequencer_pkg::*;
#(
   parameter int WIDTH = SEQ_WIDTH
);

   logic             START;
   mode_e            MODE;
   logic [WIDTH-1:0] DATA1;
   logic [7:0]       DATA2;
   logic             BUSY;
   logic             DONE;
   logic [WIDTH-1:0] RESULT;
   logic             ZERO;

   modport master (
      output START, MODE, DATA1, DATA2,
      input  BUSY, DONE, RESULT, ZERO
   );

   modport slave (
      input  START, MODE, DATA1, DATA2,
      output BUSY, DONE, RESULT, ZERO
   );

endinterface

// File: rtl/shift_sequencer_step_unit.sv
// Combinational single-bit shift of the working word.
// One instance per step taken in a cycle.
module shift_step_unit
   import shift_sequencer_pkg::*;
#(
   parameter int WIDTH = SEQ_WIDTH
) (
   input  mode_e            mode,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_comb begin
      q = d;
      unique case (1'b1)
         (mode == SHIFT_ROR): q = {d[0], d[WIDTH-1:1]};
         (mode == SHIFT_SLL): q = {d[WIDTH-2:0], 1'b0};
         (mode == SHIFT_SRL): q = {1'b0, d[WIDTH-1:1]};
         (mode == SHIFT_SRA): q = {d[WIDTH-1], d[WIDTH-1:1]};
         default:             q = d;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative ROR/SLL/SRL/SRA sequencer with start/done handshake.
// Define SHIFT_SEQ_DOUBLE_STEP_EN to take two steps per cycle.
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int WIDTH = SEQ_WIDTH
) (
   input logic               CLK,
   input logic               RESET,
   shift_sequencer_if.slave  bus
);

   localparam int CW = cnt_width(WIDTH);

   state_e           state;
   mode_e            mode_q;
   logic [WIDTH-1:0] work;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] step1;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;

   // Rotates wrap, plain shifts saturate at a full clear/fill.
   function automatic logic [CW-1:0] eff_amount(
      mode_e      m,
      logic [7:0] a
   );
      int amt;
      int v;
      amt = int'(a);
      if (m == SHIFT_ROR)
         v = amt % WIDTH;
      else if (amt >= WIDTH)
         v = WIDTH;
      else
         v = amt;
      return CW'(v);
   endfunction

   shift_step_unit #(.WIDTH(WIDTH)) u_step1 (
      .mode (mode_q),
      .d    (work),
      .q    (step1)
   );

`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
   logic [WIDTH-1:0] step2;

   shift_step_unit #(.WIDTH(WIDTH)) u_step2 (
      .mode (mode_q),
      .d    (step1),
      .q    (step2)
   );
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state    <= IDLE;
         mode_q   <= SHIFT_ROR;
         work     <= '0;
         count    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.START) begin
                  work   <= bus.DATA1;
                  mode_q <= bus.MODE;
                  count  <= eff_amount(bus.MODE, bus.DATA2);
                  busy_q <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               if (count == '0) begin
                  result_q <= work;
                  zero_q   <= (work == '0);
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state    <= FINISH;
               end else begin
`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
                  if (count >= CW'(2)) begin
                     work  <= step2;
                     count <= count - CW'(2);
                  end else begin
                     work  <= step1;
                     count <= count - CW'(1);
                  end
`else
                  work  <= step1;
                  count <= count - CW'(1);
`endif
               end
            end
            FINISH: begin
               done_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.BUSY   = busy_q;
   assign bus.DONE   = done_q;
   assign bus.RESULT = result_q;
   assign bus.ZERO   = zero_q;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle sequencer for the ALU right/left shift operations (ROR, SRL, SRA, SLL). It accepts an operand, a shift amount and a shift mode under a start/done handshake, then iterates a one-bit shift step until the amount is used up. The result is registered and held. It sits beside the ALU and lets the control unit stall on `BUSY` instead of paying for a full combinational barrel shifter.

## Interface
Parameters
- `WIDTH`, 8: operand/result width in bits.

Ports
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RESET` input 1: asynchronous, active-high reset.
- `START` input 1: request; sampled only in IDLE.
- `MODE` input 2: shift mode; 00 ROR, 01 SLL, 10 SRL, 11 SRA.
- `DATA1` input WIDTH: operand.
- `DATA2` input 8: shift amount, unsigned.
- `BUSY` output 1: high from the edge after accept until the cycle DONE rises.
- `DONE` output 1: one-cycle pulse when RESULT becomes valid.
- `RESULT` output WIDTH: registered result, held until the next DONE.
- `ZERO` output 1: registered, equals (RESULT == 0).

## Operation
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - START=1 at an edge loads the working register with DATA1, latches MODE, loads count with the effective amount, and goes to SHIFT.
  - START=0 stays in IDLE.
- Effective amount:
  - ROR: DATA2 mod WIDTH.
  - SLL, SRL, SRA: min(DATA2, WIDTH). Any DATA2 ≥ WIDTH behaves as exactly WIDTH steps.
- SHIFT:
  - count>0: one step per edge, then count decrements.
  - count==0: RESULT and ZERO update, and the state goes to FINISH.
- One step per mode:
  - ROR: bit0 moves to the MSB.
  - SRL: 0 moves to the MSB.
  - SRA: the MSB is replicated.
  - SLL: 0 moves to bit0.
- FINISH: DONE=1 for one cycle, then unconditional return to IDLE.
- START while in SHIFT or FINISH is ignored and not queued. START in IDLE during the DONE cycle cannot occur, because DONE is only asserted in FINISH.
- MODE, DATA1 and DATA2 are don't-care after the accept edge.
- RESET asserted at any time, including mid-shift:
  - immediate return to IDLE;
  - BUSY=0, DONE=0, RESULT=0, ZERO=1;
  - count and working register cleared;
  - the in-flight operation is discarded with no DONE.

## Timing
- Reset values: BUSY 0, DONE 0, RESULT 0, ZERO 1.
- Accept at edge E0 gives BUSY=1 from E0 through E0+n, with n the effective amount.
- RESULT and ZERO are valid after edge E0+n+1, and DONE is high during that cycle.
- Latency is n+2 edges from accept back to IDLE. Back-to-back operations therefore start every n+2 cycles at best.
- Worst case (WIDTH=8, amount ≥ 8): DONE after E0+9.

## Configuration
- `SHIFT_SEQ_DOUBLE_STEP_EN`
  - Defined: in SHIFT with count ≥ 2, two single-bit steps are applied per edge and count decreases by 2. count==1 takes one step. BUSY spans ceil(n/2)+1 edges and DONE follows after E0+ceil(n/2)+1.
  - Undefined: one step per edge as above.
- Results are identical in both builds; only latency differs.

## Structure
- Shared package holds:
  - MODE encodings (`SHIFT_ROR`, `SHIFT_SLL`, `SHIFT_SRL`, `SHIFT_SRA`);
  - state encodings (IDLE, SHIFT, FINISH);
  - count width, $clog2(WIDTH)+1.
- One sub-module, `shift_step_unit`: combinational single-bit shift of WIDTH bits selected by MODE. It is instantiated once, or chained twice under `SHIFT_SEQ_DOUBLE_STEP_EN`.
- FSM, counter and output registers live in the top module.

## Test plan
1. Reset, then MODE=11, DATA1=0x80, DATA2=3, START pulse -> RESULT=0xF0, DONE after E0+4, BUSY high for 4 edges.
2. MODE=00, DATA1=0xF1, DATA2=10 -> effective 2, RESULT=0x7C, DONE after E0+3.
3. MODE=10, DATA1=0xF1, DATA2=0x23 -> RESULT=0x00, ZERO=1, DONE after E0+9. With `SHIFT_SEQ_DOUBLE_STEP_EN`, DONE after E0+5.
4. MODE=01, DATA1=0x81, DATA2=0 -> RESULT=0x81, DONE after E0+1. Then MODE=01, DATA2=1 -> RESULT=0x02.
5. START MODE=11, DATA1=0x99, DATA2=5, then START again at E0+2 with DATA1=0x00 -> second request ignored, RESULT=0xFC.
6. Start SRL 0xFF by 7; assert RESET at E0+3 -> BUSY=0, DONE never pulses, RESULT=0, ZERO=1. A new ROR 0x99 by 1 after release -> RESULT=0xCC.
